mem_dump: RTL
=============

# mem_dump

Streams a range of 16-bit SDRAM words to the UART transmitter. It is the readback counterpart of `system_init`, which loads memory from serial input. On a `start` pulse it reads `word_count` words from `start_addr` through the `mem_driver` read handshake. Each word goes to `serial_driver` as two bytes, high byte first, and the stream ends with one mod-256 checksum byte.

## Interface
- `ADDR_WIDTH`, 24: memory word address width.
- `DATA_WIDTH`, 16: memory word width. Only 16 is supported (2 bytes per word).

- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a dump; sampled only in IDLE.
- `start_addr`  in  ADDR_WIDTH: first word address, captured with `start`.
- `word_count`  in  16: number of words to dump, captured with `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1: one-cycle pulse at the end of a dump.
- `mem_rdy`  in  1: memory driver can accept a request.
- `mem_cplt`  in  1: one-cycle pulse; `mem_data_out` is valid in that cycle.
- `mem_data_out`  in  DATA_WIDTH: read data.
- `mem_r_en`  out  1: one-cycle read request; `mem_addr` is valid in that cycle.
- `mem_addr`  out  ADDR_WIDTH: read address.
- `serial_out_rdy`  in  1: transmitter can accept a byte. It deasserts no later than the cycle after `serial_out_en`.
- `serial_out_en`  out  1: one-cycle byte strobe.
- `serial_data_out`  out  8: byte to send; stable while `serial_out_en` is high.

## Operation
- Reset values: all outputs are 0, state is IDLE, internal address, count, sum and data registers are 0. There is no write path (`mem_w_en` stays owned by other logic).
- States: IDLE, MEM_REQ, MEM_WAIT, TX_HI, TX_HI_W, TX_LO, TX_LO_W, TX_SUM, TX_SUM_W, DONE.
- IDLE
  - On `start`=1: capture `start_addr` into the address register and `word_count` into the remaining-count register, clear the sum, set `busy`.
  - Go to MEM_REQ if the count is non-zero, otherwise go to TX_SUM.
- MEM_REQ
  - Wait until `mem_rdy`=1.
  - In that cycle, pulse `mem_r_en` with `mem_addr` set to the current address, then go to MEM_WAIT.
- MEM_WAIT
  - On `mem_cplt`: latch `mem_data_out`, go to TX_HI.
  - `mem_cplt` in any other state is ignored.
- TX_HI / TX_LO
  - Wait until `serial_out_rdy`=1.
  - TX_HI pulses `serial_out_en` with data[15:8]; TX_LO with data[7:0].
  - Add the sent byte to the 8-bit sum, modulo 256.
  - Then go to TX_HI_W or TX_LO_W respectively.
- \*_W states: hold for exactly one cycle, ignoring `serial_out_rdy`, then move on:
  - TX_HI_W goes to TX_LO.
  - TX_LO_W: decrement the count and increment the address (wraps modulo 2^ADDR_WIDTH). Go to MEM_REQ if the count after decrement is non-zero, else TX_SUM.
  - TX_SUM_W goes to DONE.
- TX_SUM
  - Wait until `serial_out_rdy`=1, then pulse `serial_out_en` with the sum byte.
- DONE
  - Pulse `done` for one cycle, clear `busy` in the same cycle, return to IDLE.
- `start` while not in IDLE is ignored.
- A new `start` in the cycle after DONE is accepted.
- `word_count`=0 sends a single 0x00 byte with no memory access.
- `word_count`=0xFFFF is legal and sends 131071 bytes.
- Reset asserted mid-dump: all outputs clear immediately (asynchronously). No further `mem_r_en` or `serial_out_en` is issued. A pending `mem_cplt` after reset release is ignored.

## Timing
- Outputs `mem_r_en`, `mem_addr`, `serial_out_en`, `serial_data_out`, `busy` and `done` are registered.
- Start to first activity:
  - `start` is sampled at edge N; `busy`=1 from edge N+1.
  - The earliest `mem_r_en` is in cycle N+1, if `mem_rdy`=1.
- Memory to serial:
  - `mem_cplt` at edge M; the earliest high-byte `serial_out_en` is at cycle M+1.
- Byte spacing:
  - Minimum spacing between `serial_out_en` pulses is 2 cycles; real spacing is set by `serial_out_rdy`.
  - `serial_out_en` is never high while `serial_out_rdy` is 0.
- Request spacing:
  - `mem_r_en` is never high while `mem_rdy` is 0.
  - At most one memory request is outstanding.
- End of dump: `done` pulses 2 cycles after the checksum `serial_out_en`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs are 0. Release; with `start` held 0 for 20 cycles → no strobes.
- Basic dump: `start_addr`=0x000010, `word_count`=2. The memory model returns 0x1234, then 0xABCD.
  - Reads at 0x000010, then 0x000011.
  - Serial bytes 0x12, 0x34, 0xAB, 0xCD, 0xBE.
  - One `done` pulse; `busy` then falls.
- Zero count: `word_count`=0 → no `mem_r_en`; exactly one byte 0x00; `done`.
- Address wrap: `start_addr`=0xFFFFFF, `word_count`=2 → reads at 0xFFFFFF, then 0x000000.
- Backpressure: hold `serial_out_rdy` low for 100 cycles between bytes and delay `mem_rdy` and `mem_cplt` by random amounts. Pulse `start` while `busy`.
  - Byte stream is identical to the basic dump.
  - No strobe while the corresponding ready signal is low.
  - The second `start` is ignored.
- Reset mid-op: assert `rst_n`=0 after the second byte of the basic dump, then release and issue a fresh `start` with `word_count`=1 and data 0x00FF.
  - After reset: outputs clear at once and no further strobes.
  - Fresh dump: bytes 0x00, 0xFF, 0xFF.

Source files
------------

// File: rtl/mem_dump_if.sv
// Memory-read and byte-transmit handshakes shared by mem_dump and its neighbours.
// The master side belongs to mem_dump; the slave side is the memory driver plus UART transmitter.
interface mem_dump_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  serial_out_rdy;
  logic                  serial_out_en;
  logic [7:0]            serial_data_out;

  modport master (
    input  mem_rdy, mem_cplt, mem_data_out, serial_out_rdy,
    output mem_r_en, mem_addr, serial_out_en, serial_data_out
  );

  modport slave (
    output mem_rdy, mem_cplt, mem_data_out, serial_out_rdy,
    input  mem_r_en, mem_addr, serial_out_en, serial_data_out
  );
endinterface

// File: rtl/mem_dump.sv
// Streams a range of 16-bit memory words to the UART as high/low byte pairs,
// followed by a mod-256 checksum byte of everything sent.
module mem_dump #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  mem_dump_if.master            bus
);

  typedef enum logic [3:0] {
    IDLE, MEM_REQ, MEM_WAIT, TX_HI, TX_HI_W, TX_LO, TX_LO_W, TX_SUM, TX_SUM_W, DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            sum_q, sum_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  r_en_q, r_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  sout_en_q, sout_en_d;
  logic [7:0]            sout_data_q, sout_data_d;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; strobes default to 0 so they fall back after a single cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    sum_d       = sum_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    r_en_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    sout_en_d   = 1'b0;
    sout_data_d = sout_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          count_d = word_count;
          sum_d   = 8'h00;
          busy_d  = 1'b1;
          state_d = (word_count != 16'd0) ? MEM_REQ : TX_SUM;
        end
      end
      MEM_REQ: begin
        if (bus.mem_rdy) begin
          r_en_d     = 1'b1;
          mem_addr_d = addr_q;
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_cplt) begin
          data_d  = bus.mem_data_out;
          state_d = TX_HI;
        end
      end
      TX_HI: begin
        if (bus.serial_out_rdy) begin
          sout_en_d   = 1'b1;
          sout_data_d = data_q[15:8];
          sum_d       = sum_q + data_q[15:8];
          state_d     = TX_HI_W;
        end
      end
      // The *_W states give the transmitter one cycle to drop its ready.
      TX_HI_W: state_d = TX_LO;
      TX_LO: begin
        if (bus.serial_out_rdy) begin
          sout_en_d   = 1'b1;
          sout_data_d = data_q[7:0];
          sum_d       = sum_q + data_q[7:0];
          state_d     = TX_LO_W;
        end
      end
      TX_LO_W: begin
        count_d = count_q - 16'd1;
        addr_d  = addr_q + ADDR_ONE;
        state_d = (count_q != 16'd1) ? MEM_REQ : TX_SUM;
      end
      TX_SUM: begin
        if (bus.serial_out_rdy) begin
          sout_en_d   = 1'b1;
          sout_data_d = sum_q;
          state_d     = TX_SUM_W;
        end
      end
      TX_SUM_W: state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and are all cleared by
  // the asynchronous reset, so a mid-dump reset silences both strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r_en_q      <= 1'b0;
      mem_addr_q  <= '0;
      sout_en_q   <= 1'b0;
      sout_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      r_en_q      <= r_en_d;
      mem_addr_q  <= mem_addr_d;
      sout_en_q   <= sout_en_d;
      sout_data_q <= sout_data_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign bus.mem_r_en        = r_en_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.serial_out_en   = sout_en_q;
  assign bus.serial_data_out = sout_data_q;

endmodule
